// File: rtl/tristate_bus_transceiver_if.sv
// ============================================================================
//  Module      : tristate_bus_transceiver_if
//  Description : Groups the request/response and the bus control signals of
//                the tristate bus transceiver. The shared data bus is a
//                resolved tristate net, so it is a separate inout port on the
//                controller and is not part of this interface.
//  Modports    : master - the bus-owning controller
//                         (inputs: req, we, wdata, bus_ack;
//                          outputs: rdata, busy, done, err, bus_oe,
//                          bus_strobe, bus_dir)
//                slave  - the requester and far-end responder side
//                         (inputs: rdata, busy, done, err, bus_oe,
//                          bus_strobe, bus_dir;
//                          outputs: req, we, wdata, bus_ack)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tristate_bus_transceiver_if #(
    parameter int WIDTH = 8
);
    logic             req;
    logic             we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             busy;
    logic             done;
    logic             err;
    logic             bus_oe;
    logic             bus_strobe;
    logic             bus_dir;
    logic             bus_ack;

    modport master (
        input  req, we, wdata, bus_ack,
        output rdata, busy, done, err, bus_oe, bus_strobe, bus_dir
    );

    modport slave (
        output req, we, wdata, bus_ack,
        input  rdata, busy, done, err, bus_oe, bus_strobe, bus_dir
    );
endinterface

`default_nettype wire

// File: rtl/tristate_bus_transceiver.sv
// ============================================================================
//  Module      : tristate_bus_transceiver
//  Description : Controller for the owning end of a shared, bidirectional,
//                tristate data bus. Drives latched data during writes,
//                releases the bus during reads and samples the responder's
//                data on acknowledge. A strobe/ack handshake paces each
//                transfer; every transfer ends with a turnaround cycle.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous reset, active high
//                bif  - master modport: req/we/wdata in, rdata/busy/done/err
//                       out, bus_oe/bus_strobe/bus_dir out, bus_ack in
//                bus  - shared data bus, driven only while bus_oe is high
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tristate_bus_transceiver #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 15
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    tristate_bus_transceiver_if.master      bif,
    inout  wire       [WIDTH-1:0]           bus
);

    // Counter only has to reach TIMEOUT-1.
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_STROBE = 3'd2,
        WR_HOLD   = 3'd3,
        RD_STROBE = 3'd4,
        TURN      = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_timeout_err;
    logic               w_load;
    logic               w_rd_capture;

    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_rdata;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               r_bus_oe;
    logic               r_bus_strobe;
    logic               r_bus_dir;

    // Request is only honoured in IDLE; wdata/we changes later are ignored.
    assign w_load       = (r_state == IDLE) && bif.req;
    assign w_rd_capture = (r_state == RD_STROBE) && bif.bus_ack;

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_timeout_err = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bif.req) begin
                    w_cnt_next   = '0;
                    w_state_next = bif.we ? WR_SETUP : RD_STROBE;
                end
            end
            WR_SETUP: begin
                w_state_next = WR_STROBE;
            end
            WR_STROBE: begin
                w_cnt_next = r_cnt + c_CNT_W'(1);
                if (bif.bus_ack) begin
                    w_state_next = WR_HOLD;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next  = TURN;
                    w_timeout_err = 1'b1;
                end
            end
            WR_HOLD: begin
                w_state_next = TURN;
            end
            RD_STROBE: begin
                w_cnt_next = r_cnt + c_CNT_W'(1);
                if (bif.bus_ack) begin
                    w_state_next = TURN;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_next  = TURN;
                    w_timeout_err = 1'b1;
                end
            end
            TURN: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state they describe. bus_oe is high only in the three write states,
    // so it can never be set in RD_STROBE, TURN or the cycle after TURN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_data       <= '0;
            r_rdata      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_bus_oe     <= 1'b0;
            r_bus_strobe <= 1'b0;
            r_bus_dir    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            if (w_load) begin
                r_data <= bif.wdata;
            end
            if (w_rd_capture) begin
                r_rdata <= bus;
            end
            r_busy       <= (w_state_next != IDLE);
            r_done       <= (w_state_next == TURN);
            r_err        <= w_timeout_err;
            r_bus_oe     <= (w_state_next == WR_SETUP) ||
                            (w_state_next == WR_STROBE) ||
                            (w_state_next == WR_HOLD);
            r_bus_strobe <= (w_state_next == WR_STROBE) ||
                            (w_state_next == RD_STROBE);
            r_bus_dir    <= (w_state_next == WR_STROBE);
        end
    end

    assign bus            = r_bus_oe ? r_data : {WIDTH{1'bz}};
    assign bif.rdata      = r_rdata;
    assign bif.busy       = r_busy;
    assign bif.done       = r_done;
    assign bif.err        = r_err;
    assign bif.bus_oe     = r_bus_oe;
    assign bif.bus_strobe = r_bus_strobe;
    assign bif.bus_dir    = r_bus_dir;

endmodule

`default_nettype wire

// File: tb/tb_tristate_bus_transceiver.sv
// ============================================================================
//  Module      : tb_tristate_bus_transceiver
//  Description : Directed self-checking bench for tristate_bus_transceiver.
//                A small responder drives the bus while a read strobe is
//                active; a negedge monitor watches for drive overlap.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tristate_bus_transceiver;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tristate_bus_transceiver_if #(.WIDTH(WIDTH)) bif ();
    wire  [WIDTH-1:0] bus;
    logic [WIDTH-1:0] resp_val;
    logic             resp_drv;

    // Responder drives only while a read strobe is presented.
    assign resp_drv = bif.bus_strobe & ~bif.bus_dir;
    assign bus      = resp_drv ? resp_val : {WIDTH{1'bz}};

    tristate_bus_transceiver #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        check("contention", 32'(bif.bus_oe & resp_drv), 32'd0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int scount;
        int dcyc;
        int ndone;
        logic             lat_we;
        logic [WIDTH-1:0] lat_data;
        logic [WIDTH-1:0] exp_rd;
        logic             gap_pending;

        rst         = 1'b1;
        bif.req     = 1'b0;
        bif.we      = 1'b0;
        bif.wdata   = '0;
        bif.bus_ack = 1'b0;
        resp_val    = '0;
        step();
        step();
        check("rst_busy",   32'(bif.busy),       32'd0);
        check("rst_oe",     32'(bif.bus_oe),     32'd0);
        check("rst_strobe", 32'(bif.bus_strobe), 32'd0);
        check("rst_dir",    32'(bif.bus_dir),    32'd0);
        check("rst_done",   32'(bif.done),       32'd0);
        check("rst_err",    32'(bif.err),        32'd0);
        check("rst_rdata",  32'(bif.rdata),      32'd0);
        rst = 1'b0;
        step();

        // Write A5 with ack tied high: oe cycles 1-3, strobe cycle 2, done 4.
        bif.bus_ack = 1'b1;
        bif.req     = 1'b1;
        bif.we      = 1'b1;
        bif.wdata   = 8'hA5;
        step();
        bif.req   = 1'b0;
        bif.wdata = 8'h00;
        for (int i = 1; i <= 5; i++) begin
            check("wr_oe",     32'(bif.bus_oe),     32'(i <= 3));
            if (i <= 3) check("wr_bus", 32'(bus), 32'h0A5);
            check("wr_strobe", 32'(bif.bus_strobe), 32'(i == 2));
            check("wr_done",   32'(bif.done),       32'(i == 4));
            check("wr_err",    32'(bif.err),        32'd0);
            check("wr_busy",   32'(bif.busy),       32'(i <= 4));
            step();
        end

        // Reset in the middle of WR_STROBE.
        bif.bus_ack = 1'b0;
        bif.req     = 1'b1;
        bif.we      = 1'b1;
        bif.wdata   = 8'h5A;
        step();
        bif.req = 1'b0;
        step();
        check("rst_mid_strobe", 32'(bif.bus_strobe), 32'd1);
        rst = 1'b1;
        step();
        check("rst_mid_oe",     32'(bif.bus_oe),     32'd0);
        check("rst_mid_busy",   32'(bif.busy),       32'd0);
        check("rst_mid_strobe0",32'(bif.bus_strobe), 32'd0);
        check("rst_mid_done",   32'(bif.done),       32'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_after_done", 32'(bif.done), 32'd0);
            check("rst_after_busy", 32'(bif.busy), 32'd0);
        end

        // Read 3C, ack on the second strobe cycle.
        resp_val = 8'h3C;
        bif.req  = 1'b1;
        bif.we   = 1'b0;
        step();
        bif.req = 1'b0;
        check("rd_strobe1", 32'(bif.bus_strobe), 32'd1);
        check("rd_oe1",     32'(bif.bus_oe),     32'd0);
        check("rd_done1",   32'(bif.done),       32'd0);
        step();
        check("rd_strobe2", 32'(bif.bus_strobe), 32'd1);
        check("rd_oe2",     32'(bif.bus_oe),     32'd0);
        check("rd_bus",     32'(bus),            32'h03C);
        bif.bus_ack = 1'b1;
        step();
        bif.bus_ack = 1'b0;
        check("rd_done",  32'(bif.done),   32'd1);
        check("rd_err",   32'(bif.err),    32'd0);
        check("rd_oe3",   32'(bif.bus_oe), 32'd0);
        check("rd_rdata", 32'(bif.rdata),  32'h03C);
        step();
        check("rd_idle",  32'(bif.busy),   32'd0);

        // Read timeout: 15 strobe cycles, done in cycle 16, rdata kept.
        resp_val = 8'h55;
        bif.req  = 1'b1;
        bif.we   = 1'b0;
        step();
        bif.req = 1'b0;
        scount  = 0;
        dcyc    = 0;
        for (int i = 1; i <= 40 && dcyc == 0; i++) begin
            if (bif.bus_strobe) scount++;
            if (bif.done) begin
                dcyc = i;
                check("to_err", 32'(bif.err), 32'd1);
            end else begin
                step();
            end
        end
        check("to_strobes", 32'(scount), 32'd15);
        check("to_done_cyc", 32'(dcyc), 32'd16);
        check("to_rdata", 32'(bif.rdata), 32'h03C);
        step();

        // req held high, we and wdata changing every cycle.
        bif.bus_ack = 1'b1;
        bif.req     = 1'b1;
        lat_we      = 1'b0;
        lat_data    = '0;
        exp_rd      = '0;
        gap_pending = 1'b0;
        ndone       = 0;
        for (int c = 0; c < 40; c++) begin
            bif.we    = c[0];
            bif.wdata = 8'h10 + 8'(c);
            resp_val  = 8'hC0 + 8'(c);
            if (gap_pending) begin
                check("t5_gap", 32'(bif.busy), 32'd0);
                gap_pending = 1'b0;
            end
            if (!bif.busy) begin
                lat_we   = bif.we;
                lat_data = bif.wdata;
            end
            if (bif.bus_oe) begin
                check("t5_wbus", 32'(bus), 32'(lat_data));
                check("t5_oe_we", 32'(lat_we), 32'd1);
            end
            if (bif.bus_strobe) begin
                check("t5_dir", 32'(bif.bus_dir), 32'(lat_we));
                if (!bif.bus_dir) exp_rd = resp_val;
            end
            if (bif.done) begin
                check("t5_err", 32'(bif.err), 32'd0);
                if (!lat_we) check("t5_rdata", 32'(bif.rdata), 32'(exp_rd));
                gap_pending = 1'b1;
                ndone++;
            end
            step();
        end
        bif.req = 1'b0;
        check("t5_count", 32'(ndone), 32'd10);
        step();
        step();

        // Write FF, then a read of 00 requested during TURN.
        bif.req   = 1'b1;
        bif.we    = 1'b1;
        bif.wdata = 8'hFF;
        step();
        bif.req = 1'b0;
        check("t6_wbus", 32'(bus), 32'h0FF);
        dcyc = 0;
        for (int i = 0; i < 10 && dcyc == 0; i++) begin
            if (bif.done) dcyc = 1;
            else step();
        end
        check("t6_wdone", 32'(dcyc), 32'd1);
        check("t6_turn_oe",  32'(bif.bus_oe), 32'd0);
        check("t6_turn_drv", 32'(resp_drv),   32'd0);
        bif.req  = 1'b1;
        bif.we   = 1'b0;
        resp_val = 8'h00;
        step();
        check("t6_idle", 32'(bif.busy), 32'd0);
        step();
        bif.req = 1'b0;
        check("t6_rd_strobe", 32'(bif.bus_strobe), 32'd1);
        check("t6_rbus",      32'(bus),            32'h000);
        step();
        check("t6_rdone",  32'(bif.done),  32'd1);
        check("t6_rerr",   32'(bif.err),   32'd0);
        check("t6_rdata",  32'(bif.rdata), 32'h000);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
